// File: rtl/sid_pkg.sv
// Shared audio types and default frame constants for the serial audio blocks.
package sid;
  localparam int AUDIO_W        = 32;
  localparam int DEF_BITS       = 24;
  localparam int DEF_FRAME_BITS = 64;

  typedef struct packed {
    logic [AUDIO_W-1:0] left;
    logic [AUDIO_W-1:0] right;
  } audio_t;
endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider; rise/fall are single-clk strobes for the edge on which sclk toggles.
module i2s_clkgen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(HALF - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    sclk_d = wrap ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes are combinational so dependent registers update on the same edge as sclk.
  assign sclk = sclk_q;
  assign rise = wrap & ~sclk_q;
  assign fall = wrap & sclk_q;
endmodule

// File: rtl/i2s_dsp_master.sv
// PCM Format A (DSP mode) master: one-slot frame sync, left then right, MSB first.
module i2s_dsp_master
  import sid::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int HALF       = 4,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic   clk,
  input  logic   rst,
  output logic   i2s_sclk,
  output logic   i2s_lrclk,
  output logic   i2s_sdo,
  input  logic   i2s_sdi,
  input  audio_t audio_o,
  output audio_t audio_i,
  output logic   valid
);
  localparam int SW = $clog2(FRAME_BITS);
  localparam int TW = 2 * BITS;

  if (FRAME_BITS < 2 * BITS + 1 || HALF < 1 || BITS > AUDIO_W) begin : g_bad_params
    $error("i2s_dsp_master: need FRAME_BITS >= 2*BITS+1, HALF >= 1, BITS <= AUDIO_W");
  end

  logic rise, fall;

  i2s_clkgen #(.HALF(HALF)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .sclk (i2s_sclk),
    .rise (rise),
    .fall (fall)
  );

  logic [SW-1:0] slot_q, slot_d, slot_nxt;
  logic          lr_q, lr_d, sdo_q, sdo_d, valid_q, valid_d, first_q, first_d;
  logic [TW-1:0] tx_q, tx_d, rx_q, rx_d;
  audio_t        ai_q, ai_d;
  logic          last, rx_win, tx_win;

  always_comb begin
    slot_d   = slot_q;
    lr_d     = lr_q;
    sdo_d    = sdo_q;
    valid_d  = 1'b0;
    first_d  = first_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    ai_d     = ai_q;
    last     = (slot_q == SW'(FRAME_BITS - 1));
    slot_nxt = last ? '0 : slot_q + 1'b1;
    rx_win   = (32'(slot_q) >= 1) && (32'(slot_q) <= TW);
    tx_win   = (32'(slot_nxt) >= 1) && (32'(slot_nxt) <= TW);

    if (rise && rx_win) rx_d = {rx_q[TW-2:0], i2s_sdi};

    if (fall) begin
      slot_d = slot_nxt;
      lr_d   = last;
      sdo_d  = 1'b0;
      if (last) begin
        tx_d    = {audio_o.left[BITS-1:0], audio_o.right[BITS-1:0]};
        first_d = 1'b0;
        // The frame in flight at reset release is partial, so its data is dropped.
        if (!first_q) begin
          ai_d.left                = {AUDIO_W{rx_q[TW-1]}};
          ai_d.left[BITS-1:0]      = rx_q[TW-1 -: BITS];
          ai_d.right               = {AUDIO_W{rx_q[BITS-1]}};
          ai_d.right[BITS-1:0]     = rx_q[BITS-1:0];
          valid_d                  = 1'b1;
        end
      end else if (tx_win) begin
        sdo_d = tx_q[TW-1];
        tx_d  = {tx_q[TW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= SW'(FRAME_BITS - 1);
      lr_q    <= 1'b0;
      sdo_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b1;
      tx_q    <= '0;
      rx_q    <= '0;
      ai_q    <= '0;
    end else begin
      slot_q  <= slot_d;
      lr_q    <= lr_d;
      sdo_q   <= sdo_d;
      valid_q <= valid_d;
      first_q <= first_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ai_q    <= ai_d;
    end
  end

  logic unused_audio_hi;
  assign unused_audio_hi = ^audio_o;

  assign i2s_lrclk = lr_q;
  assign i2s_sdo   = sdo_q;
  assign audio_i   = ai_q;
  assign valid     = valid_q;
endmodule

// File: tb/tb_i2s_dsp_master.sv
// Directed bench for i2s_dsp_master (HALF=2): cycle model of sclk/slot plus a slave model.
module tb_i2s_dsp_master;
  import sid::*;

  logic   clk = 1'b0, rst, sdi;
  logic   sclk, lrclk, sdo, valid;
  audio_t audio_o, audio_i;

  i2s_dsp_master #(.BITS(24), .HALF(2), .FRAME_BITS(64)) dut (
    .clk(clk), .rst(rst), .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_sdo(sdo),
    .i2s_sdi(sdi), .audio_o(audio_o), .audio_i(audio_i), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state, owned by the monitor; main reads it 1 ns after each falling clk edge.
  int          k, slot, ent, vcnt;
  bit          first, fall, tail, last_tail;
  logic [47:0] tx_exp, rx_cur, slave_next, cap, last_tx;
  audio_t      exp_ai;
  logic        exp_valid, exp_sdo;

  always @(negedge clk) begin
    if (rst) begin
      k = 0; slot = 63; first = 1; ent = 0; vcnt = 0;
      exp_ai = '0; tx_exp = '0; cap = '0; tail = 0; sdi = 1'b0;
      chk("rst_sclk", {63'd0, sclk}, 64'd0);
      chk("rst_lrclk", {63'd0, lrclk}, 64'd0);
      chk("rst_sdo", {63'd0, sdo}, 64'd0);
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_audio_i", audio_i, 64'd0);
    end else begin
      k++;
      fall = (k % 4 == 0);
      exp_valid = 1'b0;
      if (fall) begin
        slot = (slot == 63) ? 0 : slot + 1;
        if (slot == 0) begin
          last_tx = cap; last_tail = tail; cap = '0; tail = 0;
          if (!first) begin
            exp_valid = 1'b1;
            exp_ai.left  = {{8{rx_cur[47]}}, rx_cur[47:24]};
            exp_ai.right = {{8{rx_cur[23]}}, rx_cur[23:0]};
          end
          first = 0; ent++;
          tx_exp = {audio_o.left[23:0], audio_o.right[23:0]};
          rx_cur = slave_next;
        end
      end
      exp_sdo = (slot >= 1 && slot <= 48) ? tx_exp[48-slot] : 1'b0;
      chk("sclk", {63'd0, sclk}, {63'd0, 1'(k / 2 % 2)});
      chk("lrclk", {63'd0, lrclk}, {63'd0, slot == 0});
      chk("sdo", {63'd0, sdo}, {63'd0, exp_sdo});
      chk("valid", {63'd0, valid}, {63'd0, exp_valid});
      chk("audio_i", audio_i, exp_ai);
      if (valid) vcnt++;
      if (fall) begin
        if (slot >= 1 && slot <= 48) cap[48-slot] = sdo;
        else tail = tail | sdo;
        sdi = (slot >= 1 && slot <= 48) ? rx_cur[48-slot] : 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_ent(input int n);
    int b = 0;
    while (ent < n && b < 700) begin tick(); b++; end
    chk("wait_ent_timeout", {63'd0, ent >= n}, 64'd1);
  endtask

  task automatic wait_slot(input int s);
    int b = 0;
    while (slot != s && b < 300) begin tick(); b++; end
    chk("wait_slot_timeout", {63'd0, slot == s}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    audio_o = '0;
    audio_o.left  = 32'h0080_0001;
    audio_o.right = 32'h007F_FFFE;
    slave_next = {24'hA5A5A5, 24'h000001};
    repeat (3) tick();
    rst = 1'b0;

    // Reset release: first frame sync, no valid for the partial frame.
    wait_ent(1);
    chk("first_fall_k", k, 4);
    chk("no_valid_first", vcnt, 0);
    wait_ent(2);
    chk("tx_word", last_tx, 48'h800001_7FFFFE);
    chk("tx_tail", {63'd0, last_tail}, 64'd0);
    chk("rx_a5", audio_i, 64'hFFA5A5A5_00000001);
    chk("vcnt_2", vcnt, 1);

    // Mid-frame change of audio_o / slave data only lands next frame.
    wait_slot(10);
    audio_o.left  = 32'h0012_3456;
    audio_o.right = 32'h00FE_DCBA;
    slave_next = {24'h7FFFFF, 24'h800000};
    wait_ent(3);
    chk("latch_old_tx", last_tx, 48'h800001_7FFFFE);
    chk("latch_old_rx", audio_i, 64'hFFA5A5A5_00000001);
    wait_ent(4);
    chk("latch_new_tx", last_tx, 48'h123456_FEDCBA);
    chk("latch_new_rx", audio_i, 64'h007FFFFF_FF800000);
    chk("vcnt_4", vcnt, ent - 1);

    // Reset pulse at slot 30 aborts the frame.
    wait_slot(30);
    rst = 1'b1;
    slave_next = {24'h000100, 24'hFFFFFF};
    tick();
    chk("mid_rst_audio_i", audio_i, 64'd0);
    chk("mid_rst_outs", {61'd0, sclk, lrclk, sdo}, 64'd0);
    rst = 1'b0;
    wait_ent(1);
    chk("mid_no_valid", vcnt, 0);
    chk("mid_audio_i_zero", audio_i, 64'd0);
    wait_ent(2);
    chk("mid_rx", audio_i, 64'h00000100_FFFFFFFF);
    chk("mid_tx", last_tx, 48'h123456_FEDCBA);
    chk("mid_vcnt", vcnt, 1);
    wait_ent(3);
    chk("vcnt_end", vcnt, ent - 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
